edf_irq_claim: RTL and testbench

// - Core-side responder for the EDF interrupt controller's winner/ack handshake.
// - Takes the controller's winner (valid, id, absolute deadline) and raises a core interrupt

---
 rtl/edf_pkg.sv | 29 ++
 rtl/edf_nest_stack.sv | 58 +++++
 rtl/edf_irq_claim.sv | 153 +++++++++++++++
 tb/tb_edf_irq_claim.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edf_pkg.sv
// Shared types and the wrap-safe deadline compare for the EDF claim responder.
// Stack entries use fixed maximum widths; the top zero-extends into them and truncates on read.
package edf_pkg;

    localparam int unsigned MaxIdW = 8;
    localparam int unsigned MaxTsW = 64;

    typedef struct packed {
        logic [MaxIdW-1:0] id;
        logic [MaxTsW-1:0] dl;
        logic              missed;
    } nest_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold
    } claim_state_e;

    // a is before b when the difference, taken over w bits, is negative.
    function automatic logic ts_before(input logic [MaxTsW-1:0] a,
                                       input logic [MaxTsW-1:0] b,
                                       input int unsigned       w);
        logic [MaxTsW-1:0] diff;
        diff = a - b;
        return |(diff & (MaxTsW'(1) << (w - 1)));
    endfunction

endpackage

// File: rtl/edf_nest_stack.sv
// LIFO of nested handler entries; pop+push in one cycle replaces the top,
// and set_missed_i marks the current top entry.
module edf_nest_stack
    import edf_pkg::*;
#(
    parameter int unsigned  NestDepth = 4,
    localparam int unsigned DepthW    = $clog2(NestDepth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  nest_entry_t       push_data_i,
    input  logic              set_missed_i,
    output nest_entry_t       top_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int unsigned       IdxW = (NestDepth > 1) ? $clog2(NestDepth) : 1;
    localparam logic [DepthW-1:0] Full = DepthW'(NestDepth);

    nest_entry_t       mem_q [NestDepth];
    nest_entry_t       mem_d [NestDepth];
    logic [DepthW-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]   top_idx;

    assign top_idx = IdxW'(cnt_q - 1'b1);

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (set_missed_i && cnt_q != '0) begin
            mem_d[top_idx].missed = 1'b1;
        end
        if (pop_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
        // Push lands on the slot just freed by a same-cycle pop, giving replace.
        if (push_i && cnt_d < Full) begin
            mem_d[IdxW'(cnt_d)] = push_data_i;
            cnt_d               = cnt_d + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    assign top_o   = (cnt_q != '0) ? mem_q[top_idx] : '0;
    assign depth_o = cnt_q;

endmodule

// File: rtl/edf_irq_claim.sv
// Core-side responder for the EDF controller: requests the core only for strictly
// earlier deadlines, acks claims, tracks nested handlers and flags deadline misses.
module edf_irq_claim
    import edf_pkg::*;
#(
    parameter int unsigned  NrIrqs     = 4,
    parameter int unsigned  TsWidth    = 24,
    parameter int unsigned  TsClip     = 0,
    parameter int unsigned  NestDepth  = 4,
    localparam int unsigned IdWidth    = $clog2(NrIrqs),
    localparam int unsigned OutTsWidth = TsWidth + TsClip,
    localparam int unsigned DepthW     = $clog2(NestDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  irq_valid_i,
    input  logic [IdWidth-1:0]    irq_id_i,
    input  logic [OutTsWidth-1:0] irq_dl_i,
    output logic                  irq_ack_o,
    output logic [IdWidth-1:0]    irq_id_o,
    input  logic [63:0]           mtime_i,
    input  logic                  mie_i,
    output logic                  core_irq_o,
    output logic [IdWidth-1:0]    core_irq_id_o,
    input  logic                  core_take_i,
    input  logic                  core_mret_i,
    output logic [OutTsWidth-1:0] cur_dl_o,
    output logic [DepthW-1:0]     depth_o,
    output logic                  dl_miss_o,
    output logic [15:0]           miss_cnt_o,
    output logic                  err_o
);

    localparam logic [DepthW-1:0] Full = DepthW'(NestDepth);

    claim_state_e          state_q;
    logic [IdWidth-1:0]    lat_id_q;
    logic [OutTsWidth-1:0] lat_dl_q;
    logic                  core_irq_q;
    logic                  dl_miss_q;
    logic [15:0]           miss_cnt_q;
    logic                  err_q;

    nest_entry_t           top_entry;
    nest_entry_t           push_entry;
    logic [DepthW-1:0]     depth;
    logic [OutTsWidth-1:0] cur_dl;
    logic [OutTsWidth-1:0] mtime_ts;
    logic                  preempt;
    logic                  take_ok;
    logic                  pop;
    logic                  miss_hit;
    logic                  unused_sig;

    assign cur_dl   = top_entry.dl[OutTsWidth-1:0];
    assign mtime_ts = mtime_i[OutTsWidth-1+TsClip:TsClip];

    assign preempt = irq_valid_i && mie_i && (depth < Full) &&
                     ((depth == '0) ||
                      ts_before(MaxTsW'(irq_dl_i), MaxTsW'(cur_dl), OutTsWidth));

    assign take_ok  = (state_q == StReq) && core_take_i;
    assign pop      = core_mret_i && (depth != '0);
    assign miss_hit = (depth != '0) && !top_entry.missed &&
                      ts_before(MaxTsW'(cur_dl), MaxTsW'(mtime_ts), OutTsWidth);

    always_comb begin
        push_entry        = '0;
        push_entry.id     = MaxIdW'(lat_id_q);
        push_entry.dl     = MaxTsW'(lat_dl_q);
        push_entry.missed = 1'b0;
    end

    edf_nest_stack #(
        .NestDepth(NestDepth)
    ) u_stack (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (take_ok),
        .pop_i       (pop),
        .push_data_i (push_entry),
        .set_missed_i(miss_hit),
        .top_o       (top_entry),
        .depth_o     (depth)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            lat_id_q   <= '0;
            lat_dl_q   <= '0;
            core_irq_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (preempt) begin
                        state_q    <= StReq;
                        lat_id_q   <= irq_id_i;
                        lat_dl_q   <= irq_dl_i;
                        core_irq_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (core_take_i) begin
                        state_q    <= StHold;
                        core_irq_q <= 1'b0;
                    end else if (preempt) begin
                        lat_id_q <= irq_id_i;
                        lat_dl_q <= irq_dl_i;
                    end else if (!core_mret_i) begin
                        // An mret keeps the request alive so it is re-judged against the new top.
                        state_q    <= StIdle;
                        core_irq_q <= 1'b0;
                    end
                end
                StHold: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q    <= StIdle;
                    core_irq_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dl_miss_q  <= 1'b0;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            dl_miss_q <= miss_hit;
            if (miss_hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            err_q <= (core_mret_i && depth == '0) || (core_take_i && state_q != StReq);
        end
    end

    assign irq_ack_o     = take_ok;
    assign irq_id_o      = take_ok ? lat_id_q : '0;
    assign core_irq_o    = core_irq_q;
    assign core_irq_id_o = core_irq_q ? lat_id_q : '0;
    assign cur_dl_o      = cur_dl;
    assign depth_o       = depth;
    assign dl_miss_o     = dl_miss_q;
    assign miss_cnt_o    = miss_cnt_q;
    assign err_o         = err_q;

    assign unused_sig = ^{top_entry, mtime_i};

endmodule

// File: tb/tb_edf_irq_claim.sv
// Scoreboard bench for edf_irq_claim: a queue-based reference model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_edf_irq_claim;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        irq_valid;
    logic [1:0]  irq_id;
    logic [23:0] irq_dl;
    logic        irq_ack;
    logic [1:0]  ack_id;
    logic [63:0] mtime;
    logic        mie;
    logic        core_irq;
    logic [1:0]  core_irq_id;
    logic        core_take;
    logic        core_mret;
    logic [23:0] cur_dl;
    logic [1:0]  depth;
    logic        dl_miss;
    logic [15:0] miss_cnt;
    logic        err;

    always #5 clk = ~clk;

    edf_irq_claim #(
        .NrIrqs   (4),
        .TsWidth  (24),
        .TsClip   (0),
        .NestDepth(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .irq_valid_i  (irq_valid),
        .irq_id_i     (irq_id),
        .irq_dl_i     (irq_dl),
        .irq_ack_o    (irq_ack),
        .irq_id_o     (ack_id),
        .mtime_i      (mtime),
        .mie_i        (mie),
        .core_irq_o   (core_irq),
        .core_irq_id_o(core_irq_id),
        .core_take_i  (core_take),
        .core_mret_i  (core_mret),
        .cur_dl_o     (cur_dl),
        .depth_o      (depth),
        .dl_miss_o    (dl_miss),
        .miss_cnt_o   (miss_cnt),
        .err_o        (err)
    );

    typedef struct {
        logic        ack;
        logic [1:0]  ack_id;
        logic        irq;
        logic [1:0]  irq_id;
        logic [23:0] cur_dl;
        logic [1:0]  depth;
        logic        miss;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    typedef struct {
        logic [1:0]  id;
        logic [23:0] dl;
        bit          missed;
    } ent_t;

    exp_t        exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] mtime_v = 64'd0;

    // Reference model state
    ent_t        m_stack[$];
    bit          m_req  = 0;
    bit          m_hold = 0;
    logic [1:0]  m_id   = '0;
    logic [23:0] m_dl   = '0;
    bit          m_miss = 0;
    logic [15:0] m_cnt  = '0;
    bit          m_err  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit m_before(input int unsigned a, input int unsigned b);
        return ((a - b) % 32'h0100_0000) >= 32'h0080_0000;
    endfunction

    task automatic model_step(input bit v, input logic [1:0] id, input logic [23:0] dl,
                              input bit en, input bit take, input bit mret, input bit rst);
        int   n;
        bit   pre, was_req, was_hold;
        ent_t t;
        if (rst) begin
            m_stack.delete();
            m_req = 0; m_hold = 0; m_id = '0; m_dl = '0;
            m_miss = 0; m_cnt = '0; m_err = 0;
        end else begin
            n   = m_stack.size();
            pre = v && en && n < 2 && (n == 0 || m_before(dl, m_stack[n-1].dl));
            m_err  = (mret && n == 0) || (take && !m_req);
            m_miss = 0;
            if (n > 0 && !m_stack[n-1].missed && m_before(m_stack[n-1].dl, mtime_v[23:0])) begin
                t = m_stack[n-1];
                t.missed = 1;
                m_stack[n-1] = t;
                m_miss = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            was_req  = m_req;
            was_hold = m_hold;
            if (mret && n > 0) void'(m_stack.pop_back());
            if (was_req && take) begin
                t.id = m_id; t.dl = m_dl; t.missed = 0;
                m_stack.push_back(t);
            end
            m_hold = was_req && take;
            if (was_req) begin
                if (take) m_req = 0;
                else if (pre) begin m_id = id; m_dl = dl; end
                else if (!mret) m_req = 0;
            end else if (!was_hold && pre) begin
                m_req = 1; m_id = id; m_dl = dl;
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [1:0] id, input logic [23:0] dl,
                         input bit en, input bit take, input bit mret, input bit rst);
        exp_t e;
        int   n;
        rst_n = !rst; irq_valid = v; irq_id = id; irq_dl = dl; mie = en;
        core_take = take; core_mret = mret; mtime = mtime_v;
        n = m_stack.size();
        e.ack    = m_req && take;
        e.ack_id = e.ack ? m_id : 2'd0;
        e.irq    = m_req;
        e.irq_id = m_req ? m_id : 2'd0;
        e.cur_dl = (n > 0) ? m_stack[n-1].dl : 24'd0;
        e.depth  = 2'(n);
        e.miss   = m_miss;
        e.cnt    = m_cnt;
        e.err    = m_err;
        exp_q.push_back(e);
        @(posedge clk);
        model_step(v, id, dl, en, take, mret, rst);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'd0, 24'd0, 1, 0, 0, 0);
    endtask

    task automatic offer(input int n, input logic [1:0] id, input logic [23:0] dl);
        for (int i = 0; i < n; i++) cycle(1, id, dl, 1, 0, 0, 0);
    endtask

    task automatic mret_n(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'd0, 24'd0, 1, 0, 1, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("irq_ack", 64'(irq_ack), 64'(e.ack));
            chk("irq_id", 64'(ack_id), 64'(e.ack_id));
            chk("core_irq", 64'(core_irq), 64'(e.irq));
            chk("core_irq_id", 64'(core_irq_id), 64'(e.irq_id));
            chk("cur_dl", 64'(cur_dl), 64'(e.cur_dl));
            chk("depth", 64'(depth), 64'(e.depth));
            chk("dl_miss", 64'(dl_miss), 64'(e.miss));
            chk("miss_cnt", 64'(miss_cnt), 64'(e.cnt));
            chk("err", 64'(err), 64'(e.err));
        end
    end

    initial begin
        logic [23:0] rdl;
        rst_n = 1'b0; irq_valid = 0; irq_id = '0; irq_dl = '0; mie = 0;
        core_take = 0; core_mret = 0; mtime = '0;
        @(posedge clk);
        #1;
        cycle(0, 2'd0, 24'd0, 0, 0, 0, 1);
        idle(2);

        // Single irq, take on the third REQ cycle, then the same winner must not re-request
        offer(3, 2'd2, 24'd100);
        cycle(1, 2'd2, 24'd100, 1, 1, 0, 0);
        chk("single_depth", 64'(depth), 64'd1);
        chk("single_cur_dl", 64'(cur_dl), 64'd100);
        offer(5, 2'd2, 24'd100);
        chk("single_no_rereq", 64'(core_irq), 64'd0);

        // Preemption: running 500, earlier 200 nests, later 600 never requests
        mret_n(1);
        offer(2, 2'd0, 24'd500);
        cycle(1, 2'd0, 24'd500, 1, 1, 0, 0);
        idle(2);
        offer(2, 2'd1, 24'd200);
        cycle(1, 2'd1, 24'd200, 1, 1, 0, 0);
        chk("preempt_depth", 64'(depth), 64'd2);
        chk("preempt_cur_dl", 64'(cur_dl), 64'd200);
        mret_n(1);
        offer(6, 2'd3, 24'd600);
        chk("later_no_req", 64'(core_irq), 64'd0);
        mret_n(1);

        // Wrap: 0x10 is after 0xFFFFF0, 0xFFFFE0 is before it
        mtime_v = 64'h00FF_FF00;
        offer(2, 2'd0, 24'hFFFFF0);
        cycle(1, 2'd0, 24'hFFFFF0, 1, 1, 0, 0);
        idle(2);
        offer(4, 2'd1, 24'h000010);
        chk("wrap_no_req", 64'(core_irq), 64'd0);
        offer(2, 2'd2, 24'hFFFFE0);
        chk("wrap_req", 64'(core_irq), 64'd1);
        cycle(1, 2'd2, 24'hFFFFE0, 1, 1, 0, 0);
        idle(1);
        mret_n(2);

        // Miss: deadline 1000 crossed once by mtime
        mtime_v = 64'd990;
        offer(2, 2'd1, 24'd1000);
        cycle(1, 2'd1, 24'd1000, 1, 1, 0, 0);
        mtime_v = 64'd999;
        idle(3);
        mtime_v = 64'd1001;
        idle(5);
        chk("miss_cnt_once", 64'(miss_cnt), 64'd1);
        chk("miss_no_repeat", 64'(dl_miss), 64'd0);

        // Stack edges: full stack refuses, then three mrets with the last on empty
        offer(2, 2'd2, 24'd995);
        cycle(1, 2'd2, 24'd995, 1, 1, 0, 0);
        idle(2);
        offer(4, 2'd3, 24'd900);
        chk("full_no_req", 64'(core_irq), 64'd0);
        mret_n(3);
        chk("empty_depth", 64'(depth), 64'd0);
        idle(1);

        // Race: take+mret at depth 1 replaces the top
        mtime_v = 64'd0;
        offer(2, 2'd1, 24'd5000);
        cycle(1, 2'd1, 24'd5000, 1, 1, 0, 0);
        idle(2);
        offer(2, 2'd2, 24'd3000);
        cycle(1, 2'd2, 24'd3000, 1, 1, 1, 0);
        chk("race_depth", 64'(depth), 64'd1);
        chk("race_cur_dl", 64'(cur_dl), 64'd3000);
        mret_n(1);

        // Reset during REQ
        offer(2, 2'd1, 24'd50);
        cycle(1, 2'd1, 24'd50, 1, 0, 0, 1);
        chk("rst_core_irq", 64'(core_irq), 64'd0);
        chk("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        idle(1);

        // Random traffic around a slowly advancing mtime
        mtime_v = 64'h00FF_F000;
        for (int i = 0; i < 3000; i++) begin
            mtime_v = mtime_v + 64'($urandom_range(0, 3));
            rdl = mtime_v[23:0] + 24'($urandom_range(0, 220)) - 24'd20;
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rdl,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 199) == 0);
        end

        idle(1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
